// File: rtl/dmem_resp_rv32.sv
// Data-memory responder for the RV32I load/store port.
// Services one read or write at a time from a word-organised SRAM after WAIT
// wait states, and stalls the core's data side until the access completes.
module dmem_resp_rv32 #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iMEM,
  input  logic        iRW,
  input  logic [31:0] iMEMADDR,
  input  logic [31:0] iWDATA,
  input  logic [3:0]  iBE,
  output logic [31:0] oMEMDATA,
  output logic        oStallD,
  output logic        oERR
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  state_t              nextState;
  logic [3:0]          waitCnt;

  // Request captured at acceptance
  logic                reqRw;
  logic [31:0]         reqAddr;
  logic [31:0]         reqWdata;
  logic [3:0]          reqBe;

  // Request as seen by the commit logic (live inputs when WAIT = 0)
  logic                curRw;
  logic [31:0]         curAddr;
  logic [31:0]         curWdata;
  logic [3:0]          curBe;

  logic                commit;
  logic                rejected;
  logic [ADDR_W-1:0]   wordIdx;

  logic [31:0]         mem [DEPTH];

  // Next-state decode for the request sequencer
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    nextState = state;
    case (state)
      IDLE:    if (iMEM) nextState = (WAIT > 0) ? BUSY : DONE;
      BUSY:    if (waitCnt == 4'd1) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Commit selection, access checks and stall generation
  always_comb begin
    // With WAIT = 0 the request is accepted and committed on the same edge, so
    // the commit path must look at the live inputs while still in IDLE.
    if (state == IDLE) begin
      curRw    = iRW;
      curAddr  = iMEMADDR;
      curWdata = iWDATA;
      curBe    = iBE;
    end else begin
      curRw    = reqRw;
      curAddr  = reqAddr;
      curWdata = reqWdata;
      curBe    = reqBe;
    end
    commit   = iRST && (state != DONE) && (nextState == DONE);
    rejected = (curAddr[1:0] != 2'b00) || ((curAddr >> (ADDR_W + 2)) != 32'd0);
    wordIdx  = curAddr[ADDR_W+1:2];
    // Gated by reset so the stall drops the instant reset asserts.
    oStallD  = iRST && (((state == IDLE) && iMEM) || (state == BUSY));
  end

  // State register, wait counter and request capture
  always_ff @(posedge iCLK or negedge iRST) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!iRST) begin
      state    <= IDLE;
      waitCnt  <= '0;
      reqRw    <= 1'b0;
      reqAddr  <= '0;
      reqWdata <= '0;
      reqBe    <= '0;
    end else begin
      state <= nextState;
      if ((state == IDLE) && iMEM) begin
        waitCnt  <= 4'(WAIT);
        reqRw    <= iRW;
        reqAddr  <= iMEMADDR;
        reqWdata <= iWDATA;
        reqBe    <= iBE;
      end else if (state == BUSY) begin
        waitCnt <= waitCnt - 4'd1;
      end
    end
  end

  // Registered read data and error pulse, updated on the edge entering DONE
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oMEMDATA <= '0;
      oERR     <= 1'b0;
    end else begin
      oERR <= commit && rejected;
      if (commit && curRw) begin
        oMEMDATA <= rejected ? 32'd0 : mem[wordIdx];
      end
    end
  end

  // Byte-lane write into the storage array
  always_ff @(posedge iCLK) begin
    // NOTE: the storage array has no reset; clearing it would turn the RAM into
    // a bank of flops. Only the control path above is reset.
    if (commit && !curRw && !rejected) begin
      for (int b = 0; b < 4; b++) begin
        if (curBe[b]) mem[wordIdx][8*b +: 8] <= curWdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp_rv32.sv
// Self-checking bench for dmem_resp_rv32. Three instances (WAIT = 0, 2, 4)
// share one stimulus stream; each has its own reference model, expected queue
// and monitor.
module tb_dmem_resp_rv32;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  logic        iCLK;
  logic        iRST;
  logic        iMEM;
  logic        iRW;
  logic [31:0] iMEMADDR;
  logic [31:0] iWDATA;
  logic [3:0]  iBE;
  logic [31:0] memData [3];
  logic        stall   [3];
  logic        err     [3];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  for (genvar k = 0; k < 3; k++) begin : g_lane
    localparam int W = 2 * k;

    dmem_resp_rv32 #(.ADDR_W(10), .WAIT(W)) u_dut (
      .iCLK     (iCLK),
      .iRST     (iRST),
      .iMEM     (iMEM),
      .iRW      (iRW),
      .iMEMADDR (iMEMADDR),
      .iWDATA   (iWDATA),
      .iBE      (iBE),
      .oMEMDATA (memData[k]),
      .oStallD  (stall[k]),
      .oERR     (err[k])
    );

    // Reference model: memory image, one outstanding request, cycle timeline.
    exp_t        q[$];
    exp_t        e;
    logic [31:0] mm [64];
    req_t        r;
    bit          pending   = 0;
    int          doneAt    = 0;
    int          freeAt    = 0;
    int          cyc       = 0;
    int          c;
    logic [31:0] lastRd    = 32'd0;
    bit          prevStall = 0;
    bit          rej;
    bit          expStall;

    always @(negedge iRST) begin
      pending = 0;
      freeAt  = 0;
      lastRd  = 32'd0;
    end

    always @(posedge iCLK) begin
      c = cyc;
      cyc++;
      if (!iRST) begin
        pending = 0;
        freeAt  = 0;
        lastRd  = 32'd0;
      end else begin
        if (!pending && c >= freeAt && iMEM) begin
          r       = '{iRW, iMEMADDR, iWDATA, iBE};
          pending = 1;
          doneAt  = c + W + 1;
          freeAt  = c + W + 2;
        end
        if (pending && doneAt == c + 1) begin
          rej = (r.addr % 4 != 0) || (r.addr >= 32'h1000);
          if (r.rw) begin
            lastRd = rej ? 32'd0 : mm[r.addr[7:2]];
          end else if (!rej) begin
            for (int b = 0; b < 4; b++)
              if (r.be[b]) mm[r.addr[7:2]][8*b +: 8] = r.wdata[8*b +: 8];
          end
          q.push_back('{lastRd, rej});
          pending = 0;
        end
      end
    end

    // Monitor: stall every cycle; completion detected when stall falls.
    always @(negedge iCLK) begin
      if (!iRST) begin
        check($sformatf("w%0d reset stall", W), 32'(stall[k]), 32'd0);
        check($sformatf("w%0d reset err", W), 32'(err[k]), 32'd0);
        check($sformatf("w%0d reset data", W), memData[k], 32'd0);
        prevStall = 0;
      end else begin
        expStall = (!pending && cyc >= freeAt && iMEM) || pending;
        check($sformatf("w%0d stall cyc%0d", W, cyc), 32'(stall[k]), 32'(expStall));
        if (prevStall && !stall[k]) begin
          if (q.size() == 0) begin
            check($sformatf("w%0d unexpected completion cyc%0d", W, cyc), 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check($sformatf("w%0d data cyc%0d", W, cyc), memData[k], e.data);
            check($sformatf("w%0d err cyc%0d", W, cyc), 32'(err[k]), 32'(e.err));
          end
        end else begin
          check($sformatf("w%0d idle err cyc%0d", W, cyc), 32'(err[k]), 32'd0);
        end
        prevStall = stall[k];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  // One-cycle request pulse, spaced for the slowest instance (WAIT = 4)
  task automatic req(input logic rw, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be);
    iRW      = rw;
    iMEMADDR = a;
    iWDATA   = d;
    iBE      = be;
    iMEM     = 1'b1;
    step(1);
    iMEM     = 1'b0;
    step(5);
  endtask

  logic [31:0] addr;
  logic        rw;

  initial begin
    iRST = 1'b0; iMEM = 1'b0; iRW = 1'b0;
    iMEMADDR = '0; iWDATA = '0; iBE = '0;
    step(3);
    iRST = 1'b1;
    step(1);

    // Fill the 64-word working set so every later read has a known value
    for (int i = 0; i < 64; i++) req(1'b0, 32'(i * 4), $urandom, 4'hF);

    // Directed cases
    req(1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
    req(1'b1, 32'h10, 32'h0, 4'h0);
    req(1'b0, 32'h20, 32'h11223344, 4'hF);
    req(1'b0, 32'h20, 32'hAABBCCDD, 4'b0101);
    req(1'b1, 32'h20, 32'h0, 4'h0);
    req(1'b1, 32'h02, 32'h0, 4'h0);
    req(1'b0, 32'h1000, 32'h55555555, 4'hF);
    req(1'b1, 32'h00, 32'h0, 4'h0);
    req(1'b0, 32'h13, 32'h66666666, 4'hF);
    req(1'b1, 32'h10, 32'h0, 4'h0);
    req(1'b1, 32'hFC, 32'h0, 4'h0);

    // Randomized traffic, including rejected addresses
    for (int i = 0; i < 150; i++) begin
      rw   = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 63) * 4);
      case ($urandom_range(0, 7))
        0:       addr = addr | 32'($urandom_range(1, 3));
        1:       addr = addr | (32'h1000 << $urandom_range(0, 19));
        default: ;
      endcase
      req(rw, addr, $urandom, 4'($urandom_range(0, 15)));
    end

    // iMEM held high with the address changing every two cycles
    iRW  = 1'b1;
    iMEM = 1'b1;
    for (int j = 0; j < 4; j++) begin
      iMEMADDR = (j == 2) ? 32'h81 : 32'(32'h80 + j * 4);
      step(2);
    end
    iMEM = 1'b0;
    step(8);

    // Reset during the second BUSY cycle of the WAIT = 4 instance
    iRW = 1'b0; iMEMADDR = 32'h40; iWDATA = 32'hCAFEF00D; iBE = 4'hF;
    iMEM = 1'b1;
    step(1);
    iMEM = 1'b0;
    step(1);
    iRST = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("lane%0d stall drop on reset", k), 32'(stall[k]), 32'd0);
      check($sformatf("lane%0d err on reset", k), 32'(err[k]), 32'd0);
    end
    iRW = 1'b1; iMEMADDR = 32'h40; iMEM = 1'b1;
    step(2);
    iRST = 1'b1;
    step(1);
    iMEM = 1'b0;
    step(8);

    check("lane0 queue drained", 32'(g_lane[0].q.size()), 32'd0);
    check("lane1 queue drained", 32'(g_lane[1].q.size()), 32'd0);
    check("lane2 queue drained", 32'(g_lane[2].q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
